// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// instruction field codes, ALU operation codes and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RD2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // True for every opcode the controller knows how to sequence.
  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath/memory bundle. The master side supplies the
// instruction fields and status flags, the slave (controller) drives
// the datapath control lines.
interface mips_mc_controller_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               overflow;
  logic               mem_ready;

  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic               pcen;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [2:0]         alucontrol;
  logic [STATE_W-1:0] state;
  logic               instr_done;
  logic               illegal;
  logic               exc_ovf;

  modport master (
    output op, funct, zero, overflow, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           pcen, alusrcb, pcsrc, alucontrol, state, instr_done, illegal,
           exc_ovf
  );

  modport slave (
    input  op, funct, zero, overflow, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           pcen, alusrcb, pcsrc, alucontrol, state, instr_done, illegal,
           exc_ovf
  );
endinterface

// File: rtl/mips_mc_controller_aludec.sv
// R-type function decoder: maps funct to the ALU operation and flags
// function codes the ALU does not implement.
module aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  // Pure table lookup; unknown codes fall back to add with valid low.
  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      F_ADD:   alucontrol = ALU_ADD;
      F_SUB:   alucontrol = ALU_SUB;
      F_AND:   alucontrol = ALU_AND;
      F_OR:    alucontrol = ALU_OR;
      F_SLT:   alucontrol = ALU_SLT;
      default: valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode
// and the per-class execute/writeback steps, with overflow capture for
// add/sub/addi. STATE_W must be at least 4 to hold the state encoding.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                 clka,
  input  logic                 rst,
  mips_mc_controller_if.slave  bus
);

  state_t     state_q;
  logic       ovf_q;

  logic [2:0] r_alu;
  logic       r_valid;
  logic       r_addsub;
  logic       decode_bad;

  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, instr_done, illegal, exc_ovf;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  aludec u_aludec (
    .funct      (bus.funct),
    .alucontrol (r_alu),
    .valid      (r_valid)
  );

  assign r_addsub   = r_valid && ((r_alu == ALU_ADD) || (r_alu == ALU_SUB));
  assign decode_bad = !op_known(bus.op) || ((bus.op == OP_RTYPE) && !r_valid);

  // State sequencing and overflow capture; reset parks the FSM in FETCH.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ovf_q <= 1'b0;
          if (bus.mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (decode_bad) begin
            state_q <= S_FETCH;
          end else begin
            case (bus.op)
              OP_LW, OP_SW: state_q <= S_MEMADR;
              OP_RTYPE:     state_q <= S_EXEC;
              OP_BEQ:       state_q <= S_BRANCH;
              OP_ADDI:      state_q <= S_ADDIEX;
              OP_J:         state_q <= S_JUMP;
              default:      state_q <= S_FETCH;
            endcase
          end
        end
        S_MEMADR: state_q <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) state_q <= S_FETCH;
        S_EXEC: begin
          // Logical ops and slt cannot signal an arithmetic overflow.
          ovf_q   <= bus.overflow & r_addsub;
          state_q <= S_ALUWB;
        end
        S_ADDIEX: begin
          ovf_q   <= bus.overflow;
          state_q <= S_ADDIWB;
        end
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Moore output decode from the registered state; a few enables are
  // qualified by memory/ALU status of the current cycle.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    pcen       = 1'b0;
    alusrcb    = SRCB_RD2;
    pcsrc      = PC_ALU;
    alucontrol = ALU_AND;
    instr_done = 1'b0;
    illegal    = 1'b0;
    exc_ovf    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        irwrite    = bus.mem_ready;
        pcen       = bus.mem_ready;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMM_SH2;
        alucontrol = ALU_ADD;
        illegal    = decode_bad;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = r_alu;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = ~ovf_q;
        instr_done = 1'b1;
        exc_ovf    = ovf_q;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        pcen       = bus.zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_ADDIWB: begin
        regwrite   = ~ovf_q;
        instr_done = 1'b1;
        exc_ovf    = ovf_q;
      end
      S_JUMP: begin
        pcsrc      = PC_JUMP;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is held no enable may reach the datapath, even the ones
  // that follow mem_ready combinationally.
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = STATE_W'(state_q);
  assign bus.irwrite    = irwrite    & rst;
  assign bus.pcen       = pcen       & rst;
  assign bus.regwrite   = regwrite   & rst;
  assign bus.memwrite   = memwrite   & rst;
  assign bus.instr_done = instr_done & rst;
  assign bus.illegal    = illegal    & rst;
  assign bus.exc_ovf    = exc_ovf    & rst;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: instructions are expanded into
// their expected per-cycle control words from the behavioural rules, and a
// negedge monitor compares the DUT against the queued expectations.
module tb_mips_mc_controller;
  import mips_pkg::*;

  localparam int STATE_W = 4;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
  localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010;

  typedef struct packed {
    logic [STATE_W-1:0] st;
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic instr_done, illegal, exc_ovf;
  } ctl_t;

  logic clka = 1'b0;
  logic rst  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  ctl_t  exp_q[$];
  string tag_q[$];

  always #5 clka = ~clka;

  mips_mc_controller_if #(.STATE_W(STATE_W)) bus ();

  mips_mc_controller #(.STATE_W(STATE_W)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus)
  );

  function automatic ctl_t observe();
    ctl_t o;
    o.st = bus.state;
    o.iord = bus.iord; o.memwrite = bus.memwrite; o.irwrite = bus.irwrite;
    o.regdst = bus.regdst; o.memtoreg = bus.memtoreg; o.regwrite = bus.regwrite;
    o.alusrca = bus.alusrca; o.pcen = bus.pcen; o.alusrcb = bus.alusrcb;
    o.pcsrc = bus.pcsrc; o.aluc = bus.alucontrol; o.instr_done = bus.instr_done;
    o.illegal = bus.illegal; o.exc_ovf = bus.exc_ovf;
    return o;
  endfunction

  function automatic ctl_t blank(input state_t s);
    ctl_t c = '0;
    c.st = STATE_W'(s);
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected alucontrol per funct; a negative result marks an unsupported funct.
  function automatic int r_code(input logic [5:0] f);
    case (f)
      FADD: return 2;
      FSUB: return 6;
      FAND: return 0;
      FOR:  return 1;
      FSLT: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic bit op_legal(input logic [5:0] o);
    return (o == RT) || (o == LW) || (o == SW) || (o == BEQ) || (o == ADDI) || (o == JMP);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: one expected control word per clock while enabled.
  always @(negedge clka) begin
    ctl_t  e;
    ctl_t  a;
    string t;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = observe();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", t, a, e);
      end
    end
  end

  // Drive one cycle of inputs and queue the control word expected for it.
  task automatic cyc(input ctl_t e, input string tag, input logic mr, input logic z,
                     input logic ov);
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.overflow  = ov;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clka);
    #1;
  endtask

  // Reference model: expand one instruction into its cycle sequence.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int fw,
                           input int mw, input logic zv, input logic ov);
    ctl_t  e;
    string id;
    bit    ill;
    bit    ovf;
    int    rc;
    id = $sformatf("op%b_f%b", op, funct);
    bus.op    = op;
    bus.funct = funct;
    rc  = r_code(funct);
    ill = !op_legal(op) || (op == RT && rc < 0);
    for (int w = 0; w <= fw; w++) begin
      e = blank(S_FETCH);
      e.alusrcb = 2'b01; e.aluc = 3'b010;
      e.irwrite = (w == fw); e.pcen = (w == fw);
      cyc(e, {id, "_fetch"}, (w == fw), rb(), rb());
    end
    e = blank(S_DECODE);
    e.alusrcb = 2'b11; e.aluc = 3'b010; e.illegal = ill;
    cyc(e, {id, "_decode"}, rb(), rb(), rb());
    if (ill) return;
    if (op == LW || op == SW) begin
      e = blank(S_MEMADR);
      e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
      cyc(e, {id, "_memadr"}, rb(), rb(), rb());
      for (int w = 0; w <= mw; w++) begin
        if (op == LW) begin
          e = blank(S_MEMRD);
          e.iord = 1'b1;
        end else begin
          e = blank(S_MEMWR);
          e.iord = 1'b1; e.memwrite = 1'b1; e.instr_done = (w == mw);
        end
        cyc(e, {id, "_mem"}, (w == mw), rb(), rb());
      end
      if (op == LW) begin
        e = blank(S_MEMWB);
        e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
        cyc(e, {id, "_memwb"}, rb(), rb(), rb());
      end
    end else if (op == RT) begin
      e = blank(S_EXEC);
      e.alusrca = 1'b1; e.aluc = 3'(rc);
      cyc(e, {id, "_exec"}, rb(), rb(), ov);
      ovf = ov && (funct == FADD || funct == FSUB);
      e = blank(S_ALUWB);
      e.regdst = 1'b1; e.regwrite = !ovf; e.instr_done = 1'b1; e.exc_ovf = ovf;
      cyc(e, {id, "_aluwb"}, rb(), rb(), rb());
    end else if (op == BEQ) begin
      e = blank(S_BRANCH);
      e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = zv; e.instr_done = 1'b1;
      cyc(e, {id, "_branch"}, rb(), zv, rb());
    end else if (op == ADDI) begin
      e = blank(S_ADDIEX);
      e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
      cyc(e, {id, "_addiex"}, rb(), rb(), ov);
      e = blank(S_ADDIWB);
      e.regwrite = !ov; e.instr_done = 1'b1; e.exc_ovf = ov;
      cyc(e, {id, "_addiwb"}, rb(), rb(), rb());
    end else begin
      e = blank(S_JUMP);
      e.pcsrc = 2'b10; e.pcen = 1'b1; e.instr_done = 1'b1;
      cyc(e, {id, "_jump"}, rb(), rb(), rb());
    end
  endtask

  function automatic logic [6:0] enables();
    return {bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite,
            bus.instr_done, bus.illegal, bus.exc_ovf};
  endfunction

  // Abort a load in MEMRD with an asynchronous reset, then restart with
  // two FETCH wait cycles.
  task automatic reset_abort();
    mon_en = 1'b0;
    bus.op = LW; bus.funct = 6'd0; bus.mem_ready = 1'b1;
    @(posedge clka); #1;
    @(posedge clka); #1;
    bus.mem_ready = 1'b0;
    @(posedge clka); #1;
    chk("abort_in_memrd", 32'(bus.state), 32'(S_MEMRD));
    #2 bus.mem_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("abort_state_async", 32'(bus.state), 32'(S_FETCH));
    chk("abort_enables_async", 32'(enables()), 32'd0);
    @(posedge clka); #1;
    chk("abort_state_held", 32'(bus.state), 32'(S_FETCH));
    chk("abort_enables_held", 32'(enables()), 32'd0);
    #2 rst = 1'b1;
    mon_en = 1'b1;
    run_instr(LW, 6'd0, 2, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] o;
    logic [5:0] f;
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    int k;
    ops = '{RT, LW, SW, BEQ, ADDI, JMP};
    fns = '{FADD, FSUB, FAND, FOR, FSLT};
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    bus.overflow = 1'b0; bus.mem_ready = 1'b1;
    #12;
    chk("reset_state", 32'(bus.state), 32'(S_FETCH));
    chk("reset_enables", 32'(enables()), 32'd0);
    @(posedge clka); #1;
    chk("reset_enables_edge", 32'(enables()), 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    run_instr(LW,   6'd0,  0, 0, 1'b0, 1'b0);
    run_instr(SW,   6'd0,  0, 3, 1'b0, 1'b0);
    run_instr(BEQ,  6'd0,  0, 0, 1'b1, 1'b0);
    run_instr(BEQ,  6'd0,  0, 0, 1'b0, 1'b0);
    run_instr(RT,   FADD,  0, 0, 1'b0, 1'b1);
    run_instr(RT,   FSLT,  0, 0, 1'b0, 1'b1);
    run_instr(ADDI, 6'd0,  1, 0, 1'b0, 1'b1);
    run_instr(JMP,  6'd0,  0, 0, 1'b0, 1'b0);
    run_instr(6'b111111, 6'd0, 0, 0, 1'b0, 1'b0);
    run_instr(RT, 6'b000001,   0, 0, 1'b0, 1'b0);

    reset_abort();

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 7);
      f = 6'($urandom_range(0, 63));
      if (k < 6) begin
        o = ops[k];
        if (o == RT) f = fns[$urandom_range(0, 4)];
      end else if (k == 6) begin
        o = RT;
        while (r_code(f) >= 0) f = 6'($urandom_range(0, 63));
      end else begin
        o = 6'($urandom_range(0, 63));
        while (op_legal(o)) o = 6'($urandom_range(0, 63));
      end
      run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of the state register.
REQ-002 SHALL have clka  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have op  input  6  instr[31:26]; funct  input  6  instr[5:0].
REQ-005 SHALL have zero  input  1  ALU zero; overflow  input  1  ALU overflow.
REQ-006 SHALL have mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have outputs, all 1 bit: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen.
REQ-008 SHALL have outputs alusrcb 2 bits (00 rd2, 01 const 4, 10 imm, 11 imm<<2) and pcsrc 2 bits (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 SHALL have outputs alucontrol 3 bits, state STATE_W bits (debug), instr_done 1 bit, illegal 1 bit, exc_ovf 1 bit.

Function
REQ-010 SHALL be a Moore FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. Unlisted outputs are 0.
REQ-011 SHALL decode opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-012 SHALL decode R-type funct as follows, giving alucontrol: add 100000->010, sub 100010->110, and 100100->000, or 100101->001, slt 101010->111.
REQ-013 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00. irwrite=pcen=mem_ready. It SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-014 DECODE: alusrca=0, alusrcb=11, alucontrol=010. Next state: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP.
REQ-015 DECODE SHALL send an unknown opcode, or an R-type with unknown funct, to FETCH, with illegal=1 for exactly that one cycle.
REQ-016 MEMADR: alusrca=1, alusrcb=10, alucontrol=010. lw->MEMRD, sw->MEMWR.
REQ-017 MEMRD: iord=1. It SHALL stay until mem_ready, then go to MEMWB.
REQ-018 MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1, then go to FETCH.
REQ-019 MEMWR: iord=1, memwrite held at 1 until mem_ready. On mem_ready: instr_done=1, then go to FETCH.
REQ-020 EXEC: alusrca=1, alusrcb=00, alucontrol from funct, then go to ALUWB.
REQ-021 ALUWB: regdst=1, memtoreg=0, regwrite=~ovf_q, instr_done=1, then go to FETCH.
REQ-022 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero, instr_done=1, then go to FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10, alucontrol=010, then go to ADDIWB.
REQ-024 ADDIWB: regdst=0, memtoreg=0, regwrite=~ovf_q, instr_done=1, then go to FETCH.
REQ-025 JUMP: pcsrc=10, pcen=1, instr_done=1, then go to FETCH.
REQ-026 Internal ovf_q SHALL capture overflow at the end of EXEC (add/sub only; 0 for and/or/slt) and at the end of ADDIEX. It SHALL clear in FETCH.
REQ-027 exc_ovf SHALL equal ovf_q during ALUWB/ADDIWB, else 0.
REQ-028 Latency in cycles, with zero memory wait: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2. Each wait cycle adds 1 to FETCH, MEMRD and MEMWR.
REQ-029 An unreachable state encoding SHALL go to FETCH on the next edge with all write enables 0.

Reset
REQ-030 While rst=0, the FSM SHALL hold state=FETCH and ovf_q=0.
REQ-031 While rst=0, the following SHALL be forced to 0 regardless of mem_ready: irwrite, pcen, regwrite, memwrite, instr_done, illegal, exc_ovf.
REQ-032 Reset asserted mid-instruction SHALL abort it with no further write-enable pulse. After release, the first edge evaluates FETCH.

Structure
REQ-033 A shared package mips_pkg SHALL hold the state enum, the opcode and funct constants, and the alucontrol encodings (ALU_ADD/SUB/AND/OR/SLT).
REQ-034 A combinational sub-module aludec (funct -> alucontrol, plus valid flag) SHALL be instantiated. DECODE and EXEC both use it.
REQ-035 The state register, ovf_q and output decode SHALL live in mips_mc_controller.

Verification
REQ-036 lw (op 100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1, memtoreg=1 in cycle 5; instr_done once.
REQ-037 sw, mem_ready low for 3 cycles in MEMWR -> memwrite held 4 cycles; instr_done on the ready cycle; no regwrite.
REQ-038 beq with zero=1 -> pcen=1, pcsrc=01 in cycle 3. With zero=0 -> pcen=0, and the next cycle is FETCH.
REQ-039 R add, overflow=1 in EXEC -> ALUWB regwrite=0, exc_ovf=1. R slt, overflow=1 -> regwrite=1, exc_ovf=0.
REQ-040 op 111111, or R funct 000001 -> illegal=1 in DECODE, FETCH next, no write enables.
REQ-041 rst driven low during MEMRD -> state=FETCH asynchronously, all enables 0. FETCH with mem_ready=0 for 2 cycles -> irwrite/pcen stay 0, then pulse once.
